core_dispatch_sequencer: RTL and testbench

Sits directly downstream of the memory-mapped control block. Converts its start request (`interrupt_internal`) and per-core enable mask (`core_en`) into a launch pulse for each enabled compute core. It collects per-core completion and returns a stretched completion interrupt to the control block's `interrupt` input. It also reports busy status, timeout status and the cycle count of the last run.

---
 rtl/core_dispatch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_core_dispatch_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/core_dispatch_sequencer.sv
// core_dispatch_sequencer: turns a start request plus a per-core enable mask
// into one launch pulse per enabled core. It tracks per-core completion and
// enforces an optional run timeout. It then raises a stretched completion
// interrupt, and reports busy, timeout and last-run cycle count.
module core_dispatch_sequencer #(
    parameter int                CORE_NUM = 4,
    parameter int                CNT_W    = 16,
    parameter logic [CNT_W-1:0]  TIMEOUT  = {CNT_W{1'b1}},
    parameter int                IRQ_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CORE_NUM-1:0] core_en,
    input  logic [CORE_NUM-1:0] core_done,
    output logic [CORE_NUM-1:0] core_start,
    output logic [CORE_NUM-1:0] core_run,
    output logic                busy,
    output logic                done_irq,
    output logic                timeout_flag,
    output logic [CNT_W-1:0]    run_cycles
);

    localparam int               HOLD_W     = $clog2(IRQ_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(IRQ_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = TIMEOUT - CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                start_d_q, start_d_d;
    logic [CORE_NUM-1:0] active_mask_q, active_mask_d;
    logic [CORE_NUM-1:0] done_seen_q, done_seen_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CORE_NUM-1:0] core_start_q, core_start_d;
    logic [CORE_NUM-1:0] core_run_q, core_run_d;
    logic                busy_q, busy_d;
    logic                done_irq_q, done_irq_d;
    logic                timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0]    run_cycles_q, run_cycles_d;

    logic                launch_s;
    logic [CORE_NUM-1:0] done_eff_s;
    logic                all_done_s;
    logic [CNT_W-1:0]    cnt_inc_s;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d        = state_q;
        start_d_d      = start;
        active_mask_d  = active_mask_q;
        done_seen_d    = done_seen_q;
        cnt_d          = cnt_q;
        hold_d         = hold_q;
        core_start_d   = {CORE_NUM{1'b0}};
        core_run_d     = core_run_q;
        busy_d         = busy_q;
        done_irq_d     = done_irq_q;
        timeout_flag_d = timeout_flag_q;
        run_cycles_d   = run_cycles_q;

        launch_s  = start & ~start_d_q;
        cnt_inc_s = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_W'(1));
        // The counter is zero only in the first RUN cycle (it saturates, never
        // wraps), which is the cycle the launch pulse is visible; done pulses
        // there or earlier belong to no run and are dropped.
        if (cnt_q != {CNT_W{1'b0}}) begin
            done_eff_s = core_done & active_mask_q;
        end else begin
            done_eff_s = {CORE_NUM{1'b0}};
        end
        all_done_s = ((done_seen_q | done_eff_s) == active_mask_q);

        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    active_mask_d  = core_en;
                    done_seen_d    = {CORE_NUM{1'b0}};
                    cnt_d          = {CNT_W{1'b0}};
                    hold_d         = {HOLD_W{1'b0}};
                    timeout_flag_d = 1'b0;
                    if (core_en == {CORE_NUM{1'b0}}) begin
                        state_d      = ST_DONE;
                        run_cycles_d = {CNT_W{1'b0}};
                        busy_d       = 1'b1;
                        done_irq_d   = 1'b1;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                core_start_d = active_mask_q;
                core_run_d   = active_mask_q;
                busy_d       = 1'b1;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                done_seen_d = done_seen_q | done_eff_s;
                core_run_d  = core_run_q & ~done_eff_s;
                cnt_d       = cnt_inc_s;
                if (all_done_s) begin
                    state_d      = ST_DONE;
                    run_cycles_d = cnt_inc_s;
                    done_irq_d   = 1'b1;
                    hold_d       = {HOLD_W{1'b0}};
                end else if ((TIMEOUT != {CNT_W{1'b0}}) && (cnt_q == TIMEOUT_M1)) begin
                    state_d        = ST_DONE;
                    timeout_flag_d = 1'b1;
                    core_run_d     = {CORE_NUM{1'b0}};
                    run_cycles_d   = TIMEOUT;
                    done_irq_d     = 1'b1;
                    hold_d         = {HOLD_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (hold_q == HOLD_LAST) begin
                    done_irq_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                core_run_d = {CORE_NUM{1'b0}};
                busy_d     = 1'b0;
                done_irq_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            start_d_q      <= 1'b0;
            active_mask_q  <= {CORE_NUM{1'b0}};
            done_seen_q    <= {CORE_NUM{1'b0}};
            cnt_q          <= {CNT_W{1'b0}};
            hold_q         <= {HOLD_W{1'b0}};
            core_start_q   <= {CORE_NUM{1'b0}};
            core_run_q     <= {CORE_NUM{1'b0}};
            busy_q         <= 1'b0;
            done_irq_q     <= 1'b0;
            timeout_flag_q <= 1'b0;
            run_cycles_q   <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            start_d_q      <= start_d_d;
            active_mask_q  <= active_mask_d;
            done_seen_q    <= done_seen_d;
            cnt_q          <= cnt_d;
            hold_q         <= hold_d;
            core_start_q   <= core_start_d;
            core_run_q     <= core_run_d;
            busy_q         <= busy_d;
            done_irq_q     <= done_irq_d;
            timeout_flag_q <= timeout_flag_d;
            run_cycles_q   <= run_cycles_d;
        end
    end

    assign core_start   = core_start_q;
    assign core_run     = core_run_q;
    assign busy         = busy_q;
    assign done_irq     = done_irq_q;
    assign timeout_flag = timeout_flag_q;
    assign run_cycles   = run_cycles_q;

endmodule

// File: tb/tb_core_dispatch_sequencer.sv
// Bench for core_dispatch_sequencer: a table of runs drives the stimulus.
// A timeline model derives the expected outputs of every cycle from those
// runs, and a few literal values pin the model.
module tb_core_dispatch_sequencer;

    localparam int NS   = 8;
    localparam int TO   = 16;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  core_en = 4'd0;
    logic [3:0]  core_done = 4'd0;
    logic [3:0]  core_start;
    logic [3:0]  core_run;
    logic        busy;
    logic        done_irq;
    logic        timeout_flag;
    logic [15:0] run_cycles;

    always #5 clk = ~clk;

    core_dispatch_sequencer #(
        .CORE_NUM(4), .CNT_W(16), .TIMEOUT(16'd16), .IRQ_HOLD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .core_en(core_en),
        .core_done(core_done), .core_start(core_start), .core_run(core_run),
        .busy(busy), .done_irq(done_irq), .timeout_flag(timeout_flag),
        .run_cycles(run_cycles)
    );

    // Run table. dk = RUN-cycle index of each core's done pulse (-1 none).
    // z0 = cores also pulsing in RUN cycle 0, where the pulse must not count.
    // xs1 = RUN index of an extra start edge, xs2 = DONE offset of an extra
    // start edge, rk = RUN index at which reset is pulled (-1 none).
    int         sl[NS], hold_c[NS], xs1[NS], xs2[NS], rk[NS];
    int         dk[NS][4];
    logic [3:0] en[NS], z0[NS];
    int         dstart[NS], endk[NS], rc[NS], rr[NS], send[NS];
    bit         timed[NS];
    int         total;
    int         cyc = 0;
    bit         go = 1'b0;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic set_run(input int s, input logic [3:0] e, input int h,
                           input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] z, input int x1, input int x2, input int r);
        en[s] = e; hold_c[s] = h; z0[s] = z; xs1[s] = x1; xs2[s] = x2; rk[s] = r;
        dk[s][0] = d0; dk[s][1] = d1; dk[s][2] = d2; dk[s][3] = d3;
    endtask

    // Lay the runs out in time and derive when each one ends and how.
    task automatic plan();
        int l, k, nx;
        bit comp;
        l = 3;
        for (int s = 0; s < NS; s++) begin
            sl[s] = l;
            timed[s] = 1'b0;
            if (en[s] == 4'd0) begin
                endk[s] = 0; dstart[s] = l + 1; rc[s] = 0;
            end else begin
                k = -1; comp = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (en[s][i]) begin
                        if (dk[s][i] >= 1) k = (dk[s][i] > k) ? dk[s][i] : k;
                        else comp = 1'b0;
                    end
                end
                if (!comp) k = 1000000;
                if (k > TO - 1) begin endk[s] = TO - 1; timed[s] = 1'b1; rc[s] = TO; end
                else begin endk[s] = k; rc[s] = k + 1; end
                dstart[s] = l + 3 + endk[s];
            end
            if (rk[s] >= 0) begin rr[s] = l + 2 + rk[s]; send[s] = rr[s] + 2; end
            else begin rr[s] = -1; send[s] = dstart[s] + HOLD - 1; end
            nx = send[s];
            if (l + hold_c[s] - 1 > nx) nx = l + hold_c[s] - 1;
            if (xs2[s] >= 0 && dstart[s] + xs2[s] > nx) nx = dstart[s] + xs2[s];
            l = nx + 3;
        end
        total = l + 4;
    endtask

    // Inputs for cycle c, straight from the run table.
    task automatic drive(input int c);
        logic st, rn;
        logic [3:0] ce, cd;
        st = 1'b0; rn = (c >= 2); cd = 4'd0; ce = 4'(c * 7);
        for (int s = 0; s < NS; s++) begin
            if (c >= sl[s] && c < sl[s] + hold_c[s]) st = 1'b1;
            if (xs1[s] >= 0 && c == sl[s] + 2 + xs1[s]) st = 1'b1;
            if (xs2[s] >= 0 && c == dstart[s] + xs2[s]) st = 1'b1;
            if (c == sl[s]) ce = en[s];
            if (rr[s] >= 0 && c >= rr[s] && c <= rr[s] + 1) rn = 1'b0;
            if (rr[s] < 0 || c < rr[s]) begin
                for (int i = 0; i < 4; i++) begin
                    if (dk[s][i] >= 0 && c == sl[s] + 2 + dk[s][i]) cd[i] = 1'b1;
                    if (z0[s][i] && c == sl[s] + 2) cd[i] = 1'b1;
                end
            end
        end
        start = st; rst_n = rn; core_en = ce; core_done = cd;
    endtask

    // Expected outputs in cycle c as windows on the run timeline.
    task automatic model(input int c, output logic [3:0] e_st, output logic [3:0] e_run,
                         output logic e_busy, output logic e_irq, output logic e_to,
                         output logic [15:0] e_rc);
        int lim, b0;
        e_st = 4'd0; e_run = 4'd0; e_busy = 1'b0; e_irq = 1'b0; e_to = 1'b0; e_rc = 16'd0;
        for (int s = 0; s < NS; s++) begin
            if (sl[s] < c) begin
                e_st = 4'd0; e_run = 4'd0; e_busy = 1'b0; e_irq = 1'b0; e_to = 1'b0;
                if (rr[s] >= 0 && c >= rr[s]) begin
                    e_rc = 16'd0;
                end else begin
                    if (c >= dstart[s]) begin e_to = timed[s]; e_rc = 16'(rc[s]); end
                    if (en[s] != 4'd0 && c == sl[s] + 2) e_st = en[s];
                    for (int i = 0; i < 4; i++) begin
                        lim = (dk[s][i] >= 1 && dk[s][i] < endk[s]) ? dk[s][i] : endk[s];
                        if (en[s][i] && c >= sl[s] + 2 && c <= sl[s] + 2 + lim) e_run[i] = 1'b1;
                    end
                    b0 = (en[s] == 4'd0) ? sl[s] + 1 : sl[s] + 2;
                    if (c >= b0 && c <= dstart[s] + HOLD - 1) e_busy = 1'b1;
                    if (c >= dstart[s] && c <= dstart[s] + HOLD - 1) e_irq = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    endtask

    // Per-cycle comparison against the model plus literal pins.
    always @(negedge clk) begin
        logic [3:0]  e_st, e_run;
        logic        e_busy, e_irq, e_to;
        logic [15:0] e_rc;
        if (go) begin
            model(cyc, e_st, e_run, e_busy, e_irq, e_to, e_rc);
            chk("core_start", 32'(core_start), 32'(e_st));
            chk("core_run", 32'(core_run), 32'(e_run));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done_irq", 32'(done_irq), 32'(e_irq));
            chk("timeout_flag", 32'(timeout_flag), 32'(e_to));
            chk("run_cycles", 32'(run_cycles), 32'(e_rc));
            if (cyc == 1) chk("lit_reset_busy", 32'(busy), 32'd0);
            if (cyc == sl[0] + 2) chk("lit_s0_start", 32'(core_start), 32'hF);
            if (cyc == sl[0] + 3) chk("lit_s0_start_off", 32'(core_start), 32'h0);
            if (cyc == sl[1] + 10) chk("lit_s1_rc", 32'(run_cycles), 32'd8);
            if (cyc == sl[1] + 17) chk("lit_s1_busy_last", 32'(busy), 32'd1);
            if (cyc == sl[1] + 18) chk("lit_s1_busy_off", 32'(busy), 32'd0);
            if (cyc == sl[2] + 1) chk("lit_s2_irq", 32'(done_irq), 32'd1);
            if (cyc == sl[2] + 2) chk("lit_s2_nostart", 32'(core_start), 32'd0);
            if (cyc == sl[3] + 18) chk("lit_s3_to", 32'({timeout_flag, run_cycles, core_run}), 32'h100100);
            if (cyc == sl[4] + 1) chk("lit_s4_to_clr", 32'(timeout_flag), 32'd0);
            if (cyc == sl[5] + 6) chk("lit_s5_run", 32'(core_run), 32'h3);
            if (cyc == sl[5] + 7) chk("lit_s5_rst", 32'({core_run, busy, done_irq}), 32'd0);
            if (cyc == sl[7] + 18) chk("lit_s7_rc", 32'({timeout_flag, run_cycles}), 32'h10);
        end
    end

    // Stimulus: build the run table, then step through every cycle.
    initial begin
        set_run(0, 4'b1111, 20,  5,  6,  7,  9, 4'b0000, -1, -1, -1);
        set_run(1, 4'b0101,  3,  3,  5,  7, -1, 4'b0000, -1, -1, -1);
        set_run(2, 4'b0000,  2,  0, -1, -1, -1, 4'b0000, -1, -1, -1);
        set_run(3, 4'b0011,  1,  3, -1, -1, -1, 4'b0000, -1, -1, -1);
        set_run(4, 4'b0110,  1, -1,  2,  4, -1, 4'b0100,  2,  2, -1);
        set_run(5, 4'b0011,  1, -1, -1, -1, -1, 4'b0000, -1, -1,  5);
        set_run(6, 4'b1000,  2, -1, -1, -1, -1, 4'b1000, -1, -1, -1);
        set_run(7, 4'b0001,  1, 15, -1, -1, -1, 4'b0000, -1, -1, -1);
        plan();
        for (int c = 0; c < total; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            drive(c);
            go = 1'b1;
        end
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
